ps2_kbd: RTL and testbench

PS2_KBD -- requirements
Module: ps2_kbd

---
 rtl/ps2_kbd_pkg.sv | 51 +++++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/ps2_kbd.sv | 121 ++++++++++++
 tb/tb_ps2_kbd.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// -----------------------------------------------------------------------------
// ps2_kbd_pkg : register map, STATUS bit positions and key-event entry type
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package ps2_kbd_pkg;

  localparam logic c_REG_DATA   = 1'b0;
  localparam logic c_REG_STATUS = 1'b1;

  localparam int c_STAT_INT_EN  = 0;
  localparam int c_STAT_OVF     = 1;
  localparam int c_STAT_FULL    = 2;
  localparam int c_STAT_FLUSH   = 2;
  localparam int c_DATA_VALID   = 31;
  localparam int c_COUNT_LSB    = 24;

  // Field order follows ps2_key[9:0] so the entry is a straight copy.
  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } kbd_entry_t;

  localparam int c_ENTRY_W = $bits(kbd_entry_t);

  function automatic logic [31:0] pack_data(input logic valid, input logic [c_ENTRY_W-1:0] entry);
    logic [31:0] r;
    r = '0;
    if (valid) begin
      r[c_DATA_VALID]      = 1'b1;
      r[c_ENTRY_W-1:0]     = entry;
    end
    return r;
  endfunction

  function automatic logic [31:0] pack_status(input logic [7:0] count, input logic full,
                                              input logic ovf, input logic int_en);
    logic [31:0] r;
    r = '0;
    r[c_COUNT_LSB+:8]  = count;
    r[c_STAT_FULL]     = full;
    r[c_STAT_OVF]      = ovf;
    r[c_STAT_INT_EN]   = int_en;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with push/pop/flush and full/empty/count
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_kbd.sv
// -----------------------------------------------------------------------------
// ps2_kbd : PS/2 key-event queue behind a Wishbone DATA/STATUS register pair
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module ps2_kbd
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  input  logic [10:0] ps2_key,
  output logic        interrupt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                 r_first;
  logic                 r_prev_tog;
  logic                 r_ovf;
  logic                 r_int_en;
  logic                 r_irq;
  logic                 r_ack;
  logic [31:0]          r_dat;

  logic                 w_req;
  logic                 w_rd_data;
  logic                 w_wr_stat;
  logic                 w_flush;
  logic                 w_event;
  logic                 w_pop;
  logic                 w_ovf_set;
  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [c_ENTRY_W-1:0] w_head;
  logic [c_ENTRY_W-1:0] w_entry;
  logic                 w_unused;

  assign w_req     = i_wb_cyc & i_wb_stb;
  assign w_rd_data = w_req & ~i_wb_we & (i_wb_adr == c_REG_DATA);
  assign w_wr_stat = w_req & i_wb_we & (i_wb_adr == c_REG_STATUS) & i_wb_sel[0];
  assign w_flush   = w_wr_stat & i_wb_dat[c_STAT_FLUSH];
  assign w_pop     = w_rd_data & ~w_empty;
  assign w_entry   = ps2_key[9:0];

  // First cycle after reset only latches the toggle level, never queues it.
  assign w_event   = ~r_first & (ps2_key[10] ^ r_prev_tog);
  assign w_ovf_set = w_event & w_full & ~w_pop & ~w_flush;

  assign w_unused  = ^{i_wb_sel[3:1], i_wb_dat[31:3]};

  sync_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_event),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_first    <= 1'b1;
      r_prev_tog <= 1'b0;
      r_ovf      <= 1'b0;
      r_int_en   <= 1'b0;
      r_irq      <= 1'b0;
      r_ack      <= 1'b0;
      r_dat      <= '0;
    end else begin
      r_first    <= 1'b0;
      r_prev_tog <= ps2_key[10];
      r_ack      <= w_req;
      r_irq      <= r_int_en & ~w_empty;
      if (w_wr_stat) begin
        r_int_en <= i_wb_dat[c_STAT_INT_EN];
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_wr_stat && i_wb_dat[c_STAT_OVF]) begin
        r_ovf <= 1'b0;
      end
      if (w_req && !i_wb_we) begin
        if (i_wb_adr == c_REG_DATA) begin
          r_dat <= pack_data(~w_empty, w_head);
        end else begin
          r_dat <= pack_status(8'(w_count), w_full, r_ovf, r_int_en);
        end
      end else if (w_req) begin
        r_dat <= '0;
      end
    end
  end

  assign o_wb_dat   = r_dat;
  assign o_wb_ack   = r_ack;
  assign o_wb_stall = 1'b0;
  assign interrupt  = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd.sv
// -----------------------------------------------------------------------------
// tb_ps2_kbd : directed and random checks of ps2_kbd against a queue model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_ps2_kbd;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, adr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack, stall, irq;
  logic [10:0] ps2_key;

  logic [9:0]  q[$];
  bit          m_ovf, m_ie, m_first;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  last_entry;

  always #5 clk = ~clk;

  ps2_kbd #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .i_wb_cyc   (cyc),
    .i_wb_stb   (stb),
    .i_wb_we    (we),
    .i_wb_sel   (sel),
    .i_wb_adr   (adr),
    .i_wb_dat   (wdat),
    .o_wb_dat   (rdat),
    .o_wb_ack   (ack),
    .o_wb_stall (stall),
    .ps2_key    (ps2_key),
    .interrupt  (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model is updated from the register-map rules.
  task automatic step(input bit evt, input logic [9:0] entry, input bit acc, input bit w,
                      input bit a, input logic [3:0] s, input logic [31:0] d, input string tag);
    logic [31:0] exp_rd;
    bit          exp_irq;
    bit          flush;
    if (evt) ps2_key = {~ps2_key[10], entry};
    else     ps2_key[9:0] = 10'($urandom);
    cyc = acc; stb = acc; we = w; adr = a; sel = s; wdat = d;
    exp_irq = m_ie && (q.size() != 0);
    if (a == 1'b0) exp_rd = (q.size() != 0) ? {1'b1, 21'b0, q[0]} : 32'h0;
    else exp_rd = {8'(q.size()), 21'b0, q.size() == DEPTH, m_ovf, m_ie};
    flush = 1'b0;
    if (acc && w && a && s[0]) begin
      m_ie = d[0];
      if (d[1]) m_ovf = 1'b0;
      flush = d[2];
    end
    if (flush) q.delete();
    else begin
      if (acc && !w && !a && q.size() != 0) void'(q.pop_front());
      if (evt && !m_first) begin
        if (q.size() < DEPTH) q.push_back(entry);
        else m_ovf = 1'b1;
      end
    end
    m_first = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk({tag, ".ack"}, 32'(ack), 32'(acc));
    chk({tag, ".irq"}, 32'(irq), 32'(exp_irq));
    if (acc && !w) chk({tag, ".rdat"}, rdat, exp_rd);
  endtask

  task automatic idle();                                   step(0, '0, 0, 0, 0, 4'h0, 0, "idle"); endtask
  task automatic key(input logic [9:0] e);                 step(1, e, 0, 0, 0, 4'h0, 0, "key"); endtask
  task automatic rd_data();                                step(0, '0, 1, 0, 0, 4'hF, 0, "rd_data"); endtask
  task automatic rd_stat();                                step(0, '0, 1, 0, 1, 4'hF, 0, "rd_stat"); endtask
  task automatic wr_stat(input logic [3:0] s, input logic [31:0] d); step(0, '0, 1, 1, 1, s, d, "wr_stat"); endtask

  task automatic do_reset(input bit tog);
    rst = 1'b1; cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; wdat = 0;
    ps2_key = {tog, 10'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ack", 32'(ack), 32'h0);
    chk("reset.rdat", rdat, 32'h0);
    chk("reset.irq", 32'(irq), 32'h0);
    q.delete(); m_ovf = 0; m_ie = 0; m_first = 1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset with a stale toggle level held high
    do_reset(1'b1);
    chk("stall", 32'(stall), 32'h0);
    idle(); idle();
    rd_stat();
    chk("stale_toggle.status", rdat, 32'h0);

    // Three key events and drain
    key({1'b0, 1'b0, 8'h1C});
    key({1'b0, 1'b1, 8'h1C});
    key({1'b0, 1'b0, 8'hF0});
    rd_data(); chk("seq.r1", rdat, 32'h8000_001C);
    rd_data(); chk("seq.r2", rdat, 32'h8000_011C);
    rd_data(); chk("seq.r3", rdat, 32'h8000_00F0);
    rd_data(); chk("seq.r4", rdat, 32'h0000_0000);
    rd_stat(); chk("seq.empty", rdat, 32'h0);

    // Overflow: 17 events into 16 entries
    for (int i = 0; i < 17; i++) key(10'($urandom));
    rd_stat(); chk("ovf.status", rdat, 32'h1000_0006);
    wr_stat(4'h1, 32'h2);
    rd_stat(); chk("ovf.cleared", rdat, 32'h1000_0004);
    for (int i = 0; i < 16; i++) rd_data();
    rd_stat(); chk("ovf.drained", rdat, 32'h0);

    // Full FIFO, pop and push in the same cycle
    for (int i = 0; i < 16; i++) key(10'($urandom));
    last_entry = {1'b1, 1'b0, 8'h5A};
    step(1, last_entry, 1, 0, 0, 4'hF, 0, "full_popush");
    rd_stat(); chk("popush.status", rdat, 32'h1000_0004);
    for (int i = 0; i < 16; i++) rd_data();
    chk("popush.last", rdat, {1'b1, 21'b0, last_entry});

    // Interrupt timing
    wr_stat(4'h1, 32'h1);
    key({1'b1, 1'b0, 8'h29});
    chk("irq.after1", 32'(irq), 32'h0);
    idle();
    chk("irq.after2", 32'(irq), 32'h1);
    rd_data();
    chk("irq.read1", 32'(irq), 32'h1);
    idle();
    chk("irq.read2", 32'(irq), 32'h0);
    wr_stat(4'h1, 32'h0);

    // Flush coincident with a toggle
    for (int i = 0; i < 5; i++) key(10'($urandom));
    step(1, 10'h3AA, 1, 1, 1, 4'h1, 32'h4, "flush_push");
    rd_stat(); chk("flush.status", rdat, 32'h0);
    rd_data(); chk("flush.rd", rdat, 32'h0);

    // DATA writes and sel[0]=0 STATUS writes do nothing
    key(10'h012); key(10'h034);
    step(0, '0, 1, 1, 0, 4'hF, 32'hFFFF_FFFF, "wr_data");
    wr_stat(4'hE, 32'h7);
    rd_stat(); chk("noeffect.status", rdat, 32'h0200_0000);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] d;
      r = $urandom_range(0, 9);
      d = ($urandom & 32'hFFFF_FFFB) | ((($urandom_range(0, 7) == 0) ? 32'h4 : 32'h0));
      case (r)
        0, 1, 2, 3: key(10'($urandom));
        4, 5:       rd_data();
        6:          step(1, 10'($urandom), 1, 0, 0, 4'hF, 0, "rnd_key_rd");
        7:          rd_stat();
        8:          wr_stat(4'($urandom), d);
        default:    step(1, 10'($urandom), 1, 0, 1, 4'hF, 0, "rnd_key_stat");
      endcase
    end

    // Reset in the middle of a bus transaction
    key(10'h111); key(10'h222);
    cyc = 1; stb = 1; we = 0; adr = 0; sel = 4'hF;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midrst.ack", 32'(ack), 32'h0);
    do_reset(1'b0);
    idle();
    rd_stat(); chk("midrst.status", rdat, 32'h0);
    rd_data(); chk("midrst.rd", rdat, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
